// File: rtl/statemt_ram_ctrl.sv
// Dual-port 32-bit AES state memory with a host load/dump streaming port.
// Core ports always win; the host borrows the port-0 array path only on core-idle cycles.
module statemt_ram_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32,
    parameter int NWORDS = 16
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,

    input  logic [ADDR_W-1:0] statemt_address0,
    input  logic              statemt_ce0,
    input  logic              statemt_we0,
    input  logic [DATA_W-1:0] statemt_d0,
    output logic [DATA_W-1:0] statemt_q0,

    input  logic [ADDR_W-1:0] statemt_address1,
    input  logic              statemt_ce1,
    input  logic              statemt_we1,
    input  logic [DATA_W-1:0] statemt_d1,
    output logic [DATA_W-1:0] statemt_q1,

    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ld_done,

    input  logic              dp_start,
    output logic              dp_valid,
    output logic [DATA_W-1:0] dp_data,
    input  logic              dp_ready,
    output logic              dp_done,

    output logic              busy,
    output logic [1:0]        dbg_state
);

    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(NWORDS) + 1;

    // Handshakes: ld word moves on ld_valid & ld_ready, dump word on dp_valid & dp_ready;
    // dp_valid/dp_data never change while waiting for dp_ready.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD     = 2'd1,
        DUMP_RD  = 2'd2,
        DUMP_OUT = 2'd3
    } state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              ld_done_n, dp_done_n;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              core_active;
    logic              cnt_last;
    logic              ld_acc;
    logic              dp_acc;
    logic              rd_issue;
    logic              in0, in1;
    logic [MEM_AW-1:0] a0, a1, ha;

    if (DEPTH >= (1 << ADDR_W)) begin : g_full
        assign in0 = 1'b1;
        assign in1 = 1'b1;
    end else begin : g_part
        assign in0 = (32'(statemt_address0) < 32'(DEPTH));
        assign in1 = (32'(statemt_address1) < 32'(DEPTH));
    end

    assign a0          = MEM_AW'(statemt_address0);
    assign a1          = MEM_AW'(statemt_address1);
    assign ha          = MEM_AW'(cnt);

    assign core_active = statemt_ce0 | statemt_ce1;
    assign cnt_last    = (cnt == CNT_W'(NWORDS - 1));
    assign ld_ready    = (state == LOAD) && !core_active;
    assign ld_acc      = ld_ready && ld_valid;
    assign rd_issue    = (state == DUMP_RD) && !core_active;
    assign dp_valid    = (state == DUMP_OUT);
    assign dp_acc      = dp_valid && dp_ready;
    assign busy        = (state != IDLE);
    assign dbg_state   = state;

    // Port 1 write is ordered last so it wins a same-address write collision.
    always_ff @(posedge ap_clk) begin
        if (ld_acc) begin
            mem[ha] <= ld_data;
        end
        if (statemt_ce0 && statemt_we0 && in0) begin
            mem[a0] <= statemt_d0;
        end
        if (statemt_ce1 && statemt_we1 && in1) begin
            mem[a1] <= statemt_d1;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            statemt_q0 <= '0;
        end else if (statemt_ce0) begin
            if (!in0) begin
                statemt_q0 <= '0;
            end else if (statemt_we0) begin
                statemt_q0 <= statemt_d0;
            end else begin
                statemt_q0 <= mem[a0];
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            statemt_q1 <= '0;
        end else if (statemt_ce1) begin
            if (!in1) begin
                statemt_q1 <= '0;
            end else if (statemt_we1) begin
                statemt_q1 <= statemt_d1;
            end else begin
                statemt_q1 <= mem[a1];
            end
        end
    end

    // Holding register keeps the dumped word stable across core traffic.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            dp_data <= '0;
        end else if (rd_issue) begin
            dp_data <= mem[ha];
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            ld_done <= 1'b0;
            dp_done <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            ld_done <= ld_done_n;
            dp_done <= dp_done_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        ld_done_n = 1'b0;
        dp_done_n = 1'b0;
        case (state)
            IDLE: begin
                if (ld_start) begin
                    state_n = LOAD;
                    cnt_n   = '0;
                end else if (dp_start) begin
                    state_n = DUMP_RD;
                    cnt_n   = '0;
                end
            end
            LOAD: begin
                if (ld_acc) begin
                    cnt_n = cnt + CNT_W'(1);
                    if (cnt_last) begin
                        state_n   = IDLE;
                        ld_done_n = 1'b1;
                    end
                end
            end
            DUMP_RD: begin
                if (!core_active) begin
                    state_n = DUMP_OUT;
                end
            end
            DUMP_OUT: begin
                if (dp_acc) begin
                    if (cnt_last) begin
                        state_n   = IDLE;
                        dp_done_n = 1'b1;
                    end else begin
                        cnt_n   = cnt + CNT_W'(1);
                        state_n = DUMP_RD;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
